serial: RTL and testbench
=========================

# serial

Parallel-to-serial converter for the encode path. It accepts a `p_width`-bit word through a ready/write handshake and shifts it out MSB first, one bit per step strobe. Its bit/strobe output pair feeds a downstream bit consumer, such as the serial-to-parallel receiver or a line encoder. A one-word holding register allows back-to-back words with no idle step between them.

## Interface
Parameters:
- `p_width`, default 8: word width in bits; legal range is p_width ≥ 2.

Ports:
- `i_clk`  input  1  clock; all logic on posedge.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_dat`  input  p_width  parallel word to transmit.
- `i_wr`  input  1  write request; the word is accepted when `i_wr && o_rdy`.
- `o_rdy`  output  1  holding register empty; the block can accept a word.
- `i_stp`  input  1  bit step strobe from the bit-rate source.
- `o_val`  output  1  current serial bit, which is the MSB of the shift register.
- `o_stp`  output  1  bit strobe; `o_val` is valid and consumed this cycle.
- `o_lst`  output  1  qualifies `o_stp` on the last bit (bit 0) of a word.
- `o_bsy`  output  1  a word is being shifted (state SHIFT).

## Operation
- State register with two states: IDLE and SHIFT.
- Internal registers:
  - shift register `sh[p_width-1:0]`
  - holding register `hd[p_width-1:0]` plus full flag `hf`
  - bit index `idx`, counting 0..p_width-1
- Output equations:
  - `o_rdy = !hf`
  - `o_stp = i_stp && state==SHIFT && !i_rst`
  - `o_lst = o_stp && idx==p_width-1`
  - `o_val = sh[p_width-1]`
  - `o_bsy = state==SHIFT`
- On each `o_stp`: `sh <= {sh[p_width-2:0],1'b0}` and `idx <= idx+1`.
- On `o_lst` (the last bit is consumed):
  - if `hf` is set: `sh <= hd`, `hf <= 0`, `idx <= 0`, stay in SHIFT.
  - else, if a write is accepted in the same cycle: `sh <= i_dat`, `idx <= 0`, stay in SHIFT.
  - else: go to IDLE, with `sh <= 0` and `idx <= 0`.
- Accepted write (`i_wr && o_rdy`):
  - In IDLE: `sh <= i_dat`, `idx <= 0`, go to SHIFT; `hf` stays 0.
  - In SHIFT, not on the `o_lst` cycle: `hd <= i_dat`, `hf <= 1`.
  - In SHIFT, on the `o_lst` cycle with `hf`=0: the word goes directly into `sh`, as above.
- Ignored inputs:
  - `i_wr` while `o_rdy`=0 is ignored; `hd` is unchanged and no error is raised.
  - `i_stp` in IDLE is ignored; `o_stp` stays 0 and `sh`/`idx` are unchanged.
- Width rules:
  - `idx` is `$clog2(p_width)` bits; it wraps only through the explicit clear on `o_lst`.
  - For non-power-of-two `p_width`, `idx` never exceeds p_width-1.

## Timing
- Reset values:
  - state IDLE; `sh`=0, `hd`=0, `hf`=0, `idx`=0.
  - `o_val`=0, `o_rdy`=1, `o_bsy`=0.
  - `o_stp`=0 and `o_lst`=0, forced low during reset even if `i_stp`=1.
- Load latency: a write accepted at edge N from IDLE gives `o_bsy`=1 and `o_val`=word MSB in cycle N+1. The first `o_stp` is possible in cycle N+1.
- `o_stp`/`o_lst` are combinational from `i_stp`, so there is zero-cycle latency. The consumer samples `o_val` on the same edge at which `sh` shifts.
- A word completes after exactly p_width `o_stp` pulses, regardless of gaps between the strobes.
- Back-to-back words: when `hf`=1, or a write coincides with `o_lst`, the next word's MSB appears on `o_val` in the cycle after `o_lst`. There is no IDLE cycle between the words.
- `o_rdy` deasserts in the cycle after the write that fills `hd`. It reasserts in the cycle after the `o_lst` that empties `hd`.
- Reset mid-word: the word in flight and the held word are discarded; the block is in IDLE with reset values on the next cycle.
- Minimum strobe spacing is one cycle; `i_stp` high continuously gives one bit per clock.

## Structure
- Package `encode_pkg`: enum `t_ser_state {IDLE, SHIFT}`, shared with future encode blocks.
- Sub-module: the codebase `counter`, with `p_scale = p_width-1`, `i_inc = o_stp`, `i_dec = 0`, holds `idx`.
  - The last-bit condition uses its value output compared to p_width-1, not its wrap flag.
  - The clear on a new word is done by holding it in reset (`i_rst | load`).
- All remaining logic sits in one `always_ff` plus continuous assigns; expected size is about 150 lines.

## Test plan
- Reset with `i_stp`=1 and `i_wr`=1 asserted → `o_stp`=0, `o_rdy`=1, `o_bsy`=0, `o_val`=0 throughout reset.
- p_width=8, write 0xA5 from IDLE, `i_stp` continuously high → `o_val` on successive `o_stp` is 1,0,1,0,0,1,0,1. `o_lst` is high only on the 8th strobe, and state is IDLE after it.
- Write 0x3C, then 0xC3 two cycles later, continuous strobes → 16 contiguous strobes carry 0x3C then 0xC3. `o_rdy`=0 from the second write until the first `o_lst`. There is no bubble between the words.
- Write 0xFF while `o_rdy`=0 (holding full) → ignored; the output stream contains only the two earlier words.
- Strobes spaced irregularly (gaps of 0–5 cycles) for 0x81 → bits 1,0,0,0,0,0,0,1; `o_val` is stable between strobes.
- Reset asserted after the 3rd bit of 0xF0 with `hf`=1 → next cycle is IDLE with `o_rdy`=1. A new write of 0x0F then transmits cleanly.

Source files
------------

// File: rtl/encode_pkg.sv
// Shared definitions for the encode path blocks.
// Holds the serializer state type so later encode blocks can reuse it.
package encode_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } t_ser_state;

endpackage : encode_pkg

// File: rtl/counter.sv
// Modulo up/down counter, wrapping between 0 and p_scale.
// o_wrap flags an increment out of p_scale or a decrement out of 0.
module counter #(
    parameter int p_scale = 7,
    localparam int LP_W = (p_scale > 0) ? $clog2(p_scale + 1) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inc,
    input  logic            i_dec,
    output logic [LP_W-1:0] o_val,
    output logic            o_wrap
);

    localparam logic [LP_W-1:0] LP_TOP  = LP_W'(p_scale);
    localparam logic [LP_W-1:0] LP_ZERO = {LP_W{1'b0}};
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

    logic [LP_W-1:0] r_val;
    logic            w_up;
    logic            w_dn;

    assign w_up   = i_inc & ~i_dec;
    assign w_dn   = i_dec & ~i_inc;
    assign o_val  = r_val;
    assign o_wrap = (w_up && (r_val == LP_TOP)) || (w_dn && (r_val == LP_ZERO));

    // Count register; simultaneous inc and dec cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val <= LP_ZERO;
        end else if (w_up) begin
            r_val <= (r_val == LP_TOP) ? LP_ZERO : r_val + LP_ONE;
        end else if (w_dn) begin
            r_val <= (r_val == LP_ZERO) ? LP_TOP : r_val - LP_ONE;
        end else begin
            r_val <= r_val;
        end
    end

endmodule : counter

// File: rtl/serial.sv
// Parallel-to-serial converter: MSB-first, one bit per step strobe,
// with a one-word holding register for gapless back-to-back words.
module serial
    import encode_pkg::*;
#(
    parameter int p_width = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [p_width-1:0] i_dat,
    input  logic               i_wr,
    output logic               o_rdy,
    input  logic               i_stp,
    output logic               o_val,
    output logic               o_stp,
    output logic               o_lst,
    output logic               o_bsy
);

    localparam int                LP_IW   = $clog2(p_width);
    localparam logic [LP_IW-1:0]  LP_LAST = LP_IW'(p_width - 1);

    t_ser_state         r_state;
    t_ser_state         w_state_nxt;
    logic [p_width-1:0] r_sh;
    logic [p_width-1:0] r_hd;
    logic               r_hf;
    logic [LP_IW-1:0]   w_idx;
    logic               w_acc;
    logic               w_stp;
    logic               w_lst;
    logic               w_load;
    logic               w_idx_clr;
    logic               w_unused_wrap;

    assign w_acc  = i_wr & ~r_hf;
    assign w_stp  = i_stp && (r_state == SHIFT) && !i_rst;
    // Last bit is decoded from the index value, so it also holds for non-power-of-two widths.
    assign w_lst  = w_stp && (w_idx == LP_LAST);
    assign w_load = ((r_state == IDLE) && w_acc) || w_lst;
    assign w_idx_clr = i_rst | w_load;

    assign o_rdy = ~r_hf;
    assign o_stp = w_stp;
    assign o_lst = w_lst;
    assign o_val = r_sh[p_width-1];
    assign o_bsy = (r_state == SHIFT);

    counter #(
        .p_scale (p_width - 1)
    ) u_idx (
        .i_clk  (i_clk),
        .i_rst  (w_idx_clr),
        .i_inc  (w_stp),
        .i_dec  (1'b0),
        .o_val  (w_idx),
        .o_wrap (w_unused_wrap)
    );

    // Next-state decode: leave SHIFT only when the last bit goes with nothing queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_lst && !r_hf && !w_acc) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, shift and holding registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_sh    <= {p_width{1'b0}};
            r_hd    <= {p_width{1'b0}};
            r_hf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                if (w_acc) begin
                    r_sh <= i_dat;
                end
            end else if (w_lst) begin
                if (r_hf) begin
                    r_sh <= r_hd;
                    r_hf <= 1'b0;
                end else if (w_acc) begin
                    r_sh <= i_dat;
                end else begin
                    r_sh <= {p_width{1'b0}};
                end
            end else begin
                if (w_stp) begin
                    r_sh <= {r_sh[p_width-2:0], 1'b0};
                end
                if (w_acc) begin
                    r_hd <= i_dat;
                    r_hf <= 1'b1;
                end
            end
        end
    end

endmodule : serial

// File: tb/tb_serial.sv
// Scoreboard bench for serial: a word-queue reference model predicts the bit
// stream; a monitor pops expected bits whenever the DUT strobes.
module tb_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dat;
    logic         wr;
    logic         rdy;
    logic         stp_in;
    logic         val;
    logic         stp_out;
    logic         lst;
    logic         bsy;

    int errors = 0;
    int checks = 0;
    int exp_strobes = 0;
    int mon_strobes = 0;

    logic [W-1:0] wq[$];
    logic [1:0]   sb[$];
    int           bits_done = 0;

    serial #(.p_width(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_dat (dat),
        .i_wr  (wr),
        .o_rdy (rdy),
        .i_stp (stp_in),
        .o_val (val),
        .o_stp (stp_out),
        .o_lst (lst),
        .o_bsy (bsy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic w, input logic [W-1:0] d,
                         input logic s, input bit do_chk);
        logic         e_stp;
        logic         acc;
        logic         last;
        logic [W-1:0] head;
        @(negedge clk);
        rst = r; wr = w; dat = d; stp_in = s;
        #1;
        head  = (wq.size() > 0) ? wq[0] : '0;
        e_stp = !r && s && (wq.size() > 0);
        if (do_chk) begin
            chk("o_stp", stp_out, e_stp);
            chk("o_lst", lst, e_stp && (bits_done == W - 1));
            chk("o_rdy", rdy, wq.size() < 2);
            chk("o_bsy", bsy, wq.size() > 0);
            chk("o_val", val, (wq.size() > 0) ? head[W-1-bits_done] : 1'b0);
        end
        #2;
        if (r) begin
            wq.delete();
            sb.delete();
            bits_done = 0;
        end else begin
            acc  = w && (wq.size() < 2);
            last = e_stp && (bits_done == W - 1);
            if (e_stp) begin
                exp_strobes++;
                bits_done++;
            end
            if (last) begin
                void'(wq.pop_front());
                bits_done = 0;
            end
            if (acc) begin
                wq.push_back(d);
                for (int k = W - 1; k >= 0; k--) sb.push_back({d[k], (k == 0) ? 1'b1 : 1'b0});
            end
        end
    endtask

    // Monitor: every DUT strobe consumes one expected bit.
    always @(negedge clk) begin
        logic [1:0] e;
        #2;
        if (stp_out === 1'b1) begin
            mon_strobes++;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_strobe: got o_val=%0b with empty scoreboard at %0t", val, $time);
            end else begin
                e = sb.pop_front();
                chk("sb_bit", val, e[1]);
                chk("sb_last", lst, e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; wr = 1'b0; dat = '0; stp_in = 1'b0;
        cycle(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        cycle(1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
        for (int b = 0; b < W; b++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        cycle(1'b0, 1'b1, 8'hF0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 8'h0F, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                  W'($urandom), ($urandom_range(0, 1) == 1), 1'b1);
        end
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        #4;
        chk("sb_drained", sb.size(), 0);
        chk("strobe_count", mon_strobes, exp_strobes);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial
